// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: bus layout, mem_ctrl fields, size codes and FSM states shared by the MEM stage
package mem_stage_pkg;
  localparam int PC_W   = 32;
  localparam int RD_W   = 5;
  localparam int CTRL_W = 5;
  localparam int C_LOAD  = 4;
  localparam int C_STORE = 3;
  localparam int C_SIGN  = 2;
  localparam int C_SIZE  = 0;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;
  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, OUT} state_t;
  function automatic int ex2mem_w(input int dw, input int aw);
    return CTRL_W + dw + aw + RD_W + 1 + PC_W;
  endfunction
  function automatic int mem2wb_w(input int dw);
    return RD_W + 1 + dw + PC_W;
  endfunction
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] a);
    return (size == SZ_H && a[0]) || (size == SZ_W && a[1:0] != 2'b00) || (size == SZ_D && a != 3'b000);
  endfunction
endpackage

// File: rtl/mem_stage_load_align.sv
// load_align: picks the addressed lane out of a read word and sign/zero-extends it
module load_align #(
  parameter int DATA_W = 32,
  localparam int LB = $clog2(DATA_W / 8),
  localparam int IW = $clog2(DATA_W)
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [LB-1:0]     lane,
  input  logic [1:0]        size,
  input  logic              sign,
  output logic [DATA_W-1:0] result
);
  logic [DATA_W-1:0] sh, msk;
  logic [IW-1:0]     top;
  int                nb;
  // shift lane down, keep 2^size bytes, fill the rest with the sign bit or zeros
  always_comb begin
    sh     = rdata >> {lane, 3'b000};
    nb     = 8 << size;
    msk    = nb >= DATA_W ? '1 : ~({DATA_W{1'b1}} << nb);
    top    = IW'((nb >= DATA_W ? DATA_W : nb) - 1);
    result = (sh & msk) | ((sign && sh[top]) ? ~msk : '0);
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage issuing aligned data-memory requests and returning results to WB
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  localparam int EX2MEM_W = ex2mem_w(DATA_W, ADDR_W),
  localparam int MEM2WB_W = mem2wb_w(DATA_W)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [EX2MEM_W-1:0]   ex2mem_bus_i,
  output logic                  dm_req_o,
  input  logic                  dm_gnt_i,
  output logic                  dm_we_o,
  output logic [ADDR_W-1:0]     dm_addr_o,
  output logic [DATA_W/8-1:0]   dm_wbe_n_o,
  output logic [DATA_W-1:0]     dm_wdata_o,
  input  logic                  dm_rvalid_i,
  input  logic [DATA_W-1:0]     dm_rdata_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [MEM2WB_W-1:0]   mem2wb_bus_o,
  output logic                  exc_misalign_o
);
  localparam int LB    = $clog2(DATA_W / 8);
  localparam int NB    = DATA_W / 8;
  localparam int O_EXE = RD_W + 1 + PC_W;
  localparam int O_SD  = O_EXE + ADDR_W;
  localparam int O_CTL = O_SD + DATA_W;
  state_t                state_q, state_d;
  logic [EX2MEM_W-1:0]   bus_q;
  logic [DATA_W-1:0]     ld_q, ld_d;
  logic [CTRL_W-1:0]     ctl_q;
  logic [ADDR_W-1:0]     exe_q;
  logic [DATA_W-1:0]     sd_q, res;
  logic [LB-1:0]         lane_q;
  logic                  ld_i, st_i, accept, go_req, mis_q, is_ld_q, rv_take;
  assign ctl_q   = bus_q[O_CTL +: CTRL_W];
  assign exe_q   = bus_q[O_EXE +: ADDR_W];
  assign sd_q    = bus_q[O_SD +: DATA_W];
  assign lane_q  = exe_q[LB-1:0];
  assign ld_i    = ex2mem_bus_i[O_CTL + C_LOAD];
  assign st_i    = ex2mem_bus_i[O_CTL + C_STORE];
  // load together with store is not a memory op; misaligned ops skip memory entirely
  assign go_req  = (ld_i ^ st_i) & ~misaligned(ex2mem_bus_i[O_CTL + C_SIZE +: 2], ex2mem_bus_i[O_EXE +: 3]);
  assign mis_q   = (ctl_q[C_LOAD] ^ ctl_q[C_STORE]) & misaligned(ctl_q[C_SIZE +: 2], exe_q[2:0]);
  assign is_ld_q = ctl_q[C_LOAD] & ~ctl_q[C_STORE];
  assign in_ready_o = state_q == IDLE || (state_q == OUT && out_ready_i);
  assign accept  = in_valid_i & in_ready_o;
  // read data counts only in the grant cycle of REQ or while waiting in WAIT_R
  assign rv_take = is_ld_q & dm_rvalid_i & ((state_q == REQ && dm_gnt_i) || state_q == WAIT_R);
  assign dm_req_o   = state_q == REQ;
  assign dm_we_o    = dm_req_o & ctl_q[C_STORE];
  assign dm_addr_o  = {exe_q[ADDR_W-1:LB], {LB{1'b0}}};
  assign dm_wdata_o = sd_q << {lane_q, 3'b000};
  assign dm_wbe_n_o = dm_we_o ? ~NB'(((16'd1 << (5'd1 << ctl_q[C_SIZE +: 2])) - 16'd1) << lane_q) : '1;
  assign out_valid_o    = state_q == OUT;
  assign exc_misalign_o = out_valid_o & mis_q;
  assign res = (is_ld_q & ~mis_q) ? ld_q : DATA_W'(exe_q);
  assign mem2wb_bus_o = {bus_q[PC_W+1 +: RD_W], bus_q[PC_W] & ~mis_q, res, bus_q[PC_W-1:0]};
  load_align #(.DATA_W(DATA_W)) u_align (
    .rdata (dm_rdata_i),
    .lane  (lane_q),
    .size  (ctl_q[C_SIZE +: 2]),
    .sign  (ctl_q[C_SIGN]),
    .result(ld_d)
  );
  // next state: accept wins, then output handshake, grant and read return
  always_comb begin
    state_d = state_q;
    if (accept) state_d = go_req ? REQ : OUT;
    else if (state_q == OUT && out_ready_i) state_d = IDLE;
    else if (state_q == REQ && dm_gnt_i) state_d = (is_ld_q && !dm_rvalid_i) ? WAIT_R : OUT;
    else if (state_q == WAIT_R && dm_rvalid_i) state_d = OUT;
  end
  // state, captured op and load result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bus_q   <= '0;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) bus_q <= ex2mem_bus_i;
      if (rv_take) ld_q <= ld_d;
    end
  end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, data-path width (legal values 32 or 64); ADDR_W, default 32, address width.
REQ-002 Single clock; reset is asynchronous and active-low; ports: clk  in  1  clock; rst_n  in  1  async active-low reset.
REQ-003 in_valid_i  in  1  EX->MEM bus holds a valid op; in_ready_o  out  1  stage can accept.
REQ-004 ex2mem_bus_i  in  EX2MEM_W  fields {mem_ctrl[4:0], store_data[DATA_W], exe_result[ADDR_W], rf_wdest[4:0], rf_wen, pc[31:0]}.
REQ-005 mem_ctrl fields SHALL be {load, store, ld_sign, size[1:0]}; size is 0=byte, 1=half, 2=word, 3=dword (dword legal only when DATA_W=64).
REQ-006 dm_req_o  out  1  memory request; dm_gnt_i  in  1  request accepted; dm_we_o  out  1  1=write, 0=read.
REQ-007 dm_addr_o  out  ADDR_W  lane-aligned address; dm_wbe_n_o  out  DATA_W/8  active-low byte write enables; dm_wdata_o  out  DATA_W  lane-shifted store data.
REQ-008 dm_rvalid_i  in  1  read data valid; dm_rdata_i  in  DATA_W  read data.
REQ-009 out_valid_o  out  1  MEM->WB bus valid; out_ready_i  in  1  WB accepts; mem2wb_bus_o  out  MEM2WB_W  {rf_wdest, rf_wen, mem_result[DATA_W], pc}; exc_misalign_o  out  1  misaligned access flag, qualified by out_valid_o.

Function
REQ-010 FSM states SHALL be IDLE, REQ, WAIT_R and OUT.
REQ-011 in_ready_o SHALL be 1 in IDLE, or in OUT when out_ready_i=1 (back-to-back accept); otherwise 0.
REQ-012 On accept (in_valid_i & in_ready_o), the bus SHALL be captured into an internal register; next state is REQ for an aligned load/store, or OUT for a non-memory or misaligned op.
REQ-013 Misaligned: half with addr[0]!=0; word with addr[1:0]!=0; dword with addr[2:0]!=0. No memory request SHALL be issued; exc_misalign_o=1 and rf_wen forced to 0 in the output.
REQ-014 In REQ, dm_req_o=1 and address, data and enables stay stable until dm_gnt_i=1.
REQ-015 dm_addr_o SHALL equal exe_result with the low log2(DATA_W/8) bits cleared.
REQ-016 Store: lane = addr low bits; dm_wdata_o = store_data << 8*lane; dm_wbe_n_o low only on bytes [lane, lane+2^size-1]; gnt moves the FSM to OUT.
REQ-017 dm_wbe_n_o SHALL be all ones whenever dm_req_o=0 or dm_we_o=0.
REQ-018 Load: gnt moves the FSM to WAIT_R; if dm_rvalid_i is also 1 in the gnt cycle, the data SHALL be taken and the FSM moves directly to OUT.
REQ-019 In WAIT_R, dm_rvalid_i=1 SHALL register the load result and move the FSM to OUT.
REQ-020 Load result = (dm_rdata_i >> 8*lane), truncated to 2^size bytes, then sign-extended if ld_sign=1, zero-extended otherwise, to DATA_W.
REQ-021 mem_result SHALL be the load result for loads and zero-extended exe_result otherwise.
REQ-022 In OUT, out_valid_o=1 and mem2wb_bus_o stays stable until out_ready_i=1; then the FSM goes to IDLE, or to REQ/OUT if a new op is accepted in the same cycle.
REQ-023 Latency in cycles, accept to out_valid_o with zero memory wait: non-memory or misaligned op 1; store 2; load 2 (rvalid in the gnt cycle) or 3.
REQ-024 dm_rvalid_i outside WAIT_R and outside the REQ-with-gnt cycle SHALL be ignored.
REQ-025 load=store=1 in the same op SHALL be treated as a non-memory op.

Reset
REQ-026 While rst_n=0: FSM=IDLE, in_ready_o=1, out_valid_o=0, dm_req_o=0, dm_we_o=0, dm_wbe_n_o all ones, exc_misalign_o=0, all internal registers and mem2wb_bus_o zero.
REQ-027 Reset asserted mid-transaction SHALL abandon it; a later stale dm_rvalid_i SHALL be dropped per REQ-024.

Structure
REQ-028 A shared package SHALL hold the bus widths, the mem_ctrl field offsets, the size encodings and the FSM state enum.
REQ-029 Load extraction and extension SHALL be a sub-module, load_align (combinational, parametrised by DATA_W).

Verification
REQ-030 DATA_W=32, store byte, addr 0x1003, data 0xAB -> dm_addr_o=0x1000, dm_wbe_n_o=0111, dm_wdata_o=0xAB000000, out_valid_o 2 cycles after accept.
REQ-031 Load half signed, addr 0x2002, rdata 0x80FF1234, rvalid 2 cycles after gnt -> mem_result=0xFFFF80FF, latency 4 cycles.
REQ-032 Load word at 0x3001 -> no dm_req_o, exc_misalign_o=1, rf_wen=0, out_valid_o 1 cycle after accept.
REQ-033 Five back-to-back ALU ops with out_ready_i=1 -> one output per cycle; out_ready_i=0 for 3 cycles -> bus held stable, in_ready_o=0.
REQ-034 DATA_W=64, load byte unsigned, addr 0x..07, rdata 0x9A00_0000_0000_0000 -> mem_result=0x9A.
REQ-035 rst_n low during WAIT_R, then a stray dm_rvalid_i -> all outputs at reset values, no out_valid_o.
